btb_ctrl: RTL and testbench

Maintenance controller and write-port arbiter for the 512-entry branch target buffer. It owns the BTB's single write port and shares it between two requesters: pipeline update writes (allocate, evict, strong-bit set/clear) and a flush sweep that invalidates every entry. The sweep runs after reset and on request. While a sweep is in progress the block holds prediction disabled. It also keeps the saturating branch, hit and mispredict statistics counters fed by the BTB's stat pulses.

---
 rtl/btb_ctrl.sv | 68 ++++++
 tb/tb_btb_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/btb_ctrl.sv
// btb_ctrl: BTB write-port arbiter, flush sweeper and saturating statistics counters
module btb_ctrl #(
  parameter int ENTRIES = 512,
  parameter int IDX_W   = 9,
  parameter int ENTRY_W = 25,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req,
  input  logic               upd_we,
  input  logic [IDX_W-1:0]   upd_idx,
  input  logic [ENTRY_W-1:0] upd_data,
  output logic               btb_we,
  output logic [IDX_W-1:0]   btb_wr_idx,
  output logic [ENTRY_W-1:0] btb_wr_data,
  output logic               btb_en,
  output logic               busy,
  output logic               flush_done,
  input  logic               inc_br_cnt,
  input  logic               inc_hit_cnt,
  input  logic               inc_mispr_cnt,
  input  logic [1:0]         stat_sel,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   stat_val
);
  typedef enum logic [1:0] {SWEEP, DONE, IDLE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] br_q, hit_q, mis_q, br_d, hit_d, mis_d;
  logic sweep_wr, last;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc, input logic en, input logic clr);
    return clr ? '0 : (inc && en && !(&c)) ? c + CNT_W'(1) : c;
  endfunction
  assign sweep_wr = state_q == SWEEP && !upd_we;
  assign last     = ptr_q == IDX_W'(ENTRIES - 1);
  assign btb_en     = state_q == IDLE;
  assign busy       = state_q == SWEEP;
  assign flush_done = state_q == DONE;
  always_comb begin
    state_d = flush_req ? SWEEP : state_q == SWEEP ? ((sweep_wr && last) ? DONE : SWEEP) : IDLE;
    ptr_d   = flush_req ? '0 : sweep_wr ? (last ? '0 : ptr_q + IDX_W'(1)) : ptr_q;
    br_d    = bump(br_q, inc_br_cnt, btb_en, stat_clr);
    hit_d   = bump(hit_q, inc_hit_cnt, btb_en, stat_clr);
    mis_d   = bump(mis_q, inc_mispr_cnt, btb_en, stat_clr);
  end
  always_comb begin
    btb_we      = !rst && (state_q == SWEEP || upd_we);
    btb_wr_idx  = sweep_wr ? ptr_q : upd_idx;
    btb_wr_data = sweep_wr ? '0 : upd_data;
    stat_val    = rst ? '0 : stat_sel == 2'd0 ? br_q : stat_sel == 2'd1 ? hit_q : stat_sel == 2'd2 ? mis_q : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      br_q    <= '0;
      hit_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      br_q    <= br_d;
      hit_q   <= hit_d;
      mis_q   <= mis_d;
    end
  end
endmodule

// File: tb/tb_btb_ctrl.sv
// tb_btb_ctrl: directed self-checking bench for btb_ctrl
module tb_btb_ctrl;
  logic clk = 0, rst = 1, flush_req = 0, upd_we = 0;
  logic [8:0] upd_idx = 0;
  logic [24:0] upd_data = 0;
  logic btb_we, btb_en, busy, flush_done;
  logic [8:0] btb_wr_idx;
  logic [24:0] btb_wr_data;
  logic inc_br_cnt = 0, inc_hit_cnt = 0, inc_mispr_cnt = 0, stat_clr = 0;
  logic [1:0] stat_sel = 0;
  logic [15:0] stat_val;
  int n_cmp = 0, n_bad = 0, fd_cnt = 0;
  btb_ctrl dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .upd_we(upd_we), .upd_idx(upd_idx),
    .upd_data(upd_data), .btb_we(btb_we), .btb_wr_idx(btb_wr_idx), .btb_wr_data(btb_wr_data),
    .btb_en(btb_en), .busy(busy), .flush_done(flush_done), .inc_br_cnt(inc_br_cnt),
    .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt), .stat_sel(stat_sel),
    .stat_clr(stat_clr), .stat_val(stat_val)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (flush_done) fd_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n, b, fd0;
    repeat (2) tick;
    #1;
    check("rst_we", 32'(btb_we), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_en", 32'(btb_en), 0);
    check("rst_fd", 32'(flush_done), 0);
    check("rst_stat", 32'(stat_val), 0);
    rst = 0;
    b = 0;
    for (int i = 0; i < 512; i++) begin
      #1;
      if (!(btb_we && 32'(btb_wr_idx) == i && btb_wr_data == 25'd0)) b++;
      tick;
    end
    check("sweep_writes", b, 0);
    check("done_fd", 32'(flush_done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_en", 32'(btb_en), 0);
    check("done_we", 32'(btb_we), 0);
    tick;
    check("idle_en", 32'(btb_en), 1);
    check("idle_fd", 32'(flush_done), 0);
    check("fd_once", fd_cnt, 1);
    upd_we = 1; upd_idx = 9'd511; upd_data = 25'h1FF_FFFF;
    #1;
    check("idle_upd_we", 32'(btb_we), 1);
    check("idle_upd_idx", 32'(btb_wr_idx), 511);
    check("idle_upd_data", 32'(btb_wr_data), 32'h1FF_FFFF);
    tick;
    upd_we = 0;
    #1;
    check("idle_no_we", 32'(btb_we), 0);
    flush_req = 1;
    tick;
    flush_req = 0;
    #1;
    check("flush_en", 32'(btb_en), 0);
    check("flush_busy", 32'(busy), 1);
    check("flush_idx0", 32'(btb_wr_idx), 0);
    repeat (100) tick;
    #1;
    check("ptr100", 32'(btb_wr_idx), 100);
    upd_we = 1; upd_idx = 9'd7; upd_data = 25'h0A_BCD;
    #1;
    check("arb_we", 32'(btb_we), 1);
    check("arb_idx", 32'(btb_wr_idx), 7);
    check("arb_data", 32'(btb_wr_data), 32'h0A_BCD);
    tick;
    upd_we = 0;
    #1;
    check("ptr_held", 32'(btb_wr_idx), 100);
    check("ptr_held_data", 32'(btb_wr_data), 0);
    n = 102;
    while (!flush_done && n < 600) begin tick; n++; end
    check("stall_done_cycle", n, 514);
    tick;
    fd0 = fd_cnt;
    flush_req = 1;
    tick;
    flush_req = 0;
    inc_br_cnt = 1; inc_hit_cnt = 1; inc_mispr_cnt = 1;
    repeat (300) tick;
    #1;
    check("ptr300", 32'(btb_wr_idx), 300);
    flush_req = 1;
    tick;
    flush_req = 0;
    #1;
    check("restart_idx0", 32'(btb_wr_idx), 0);
    n = 1;
    while (!flush_done && n < 600) begin tick; n++; end
    inc_br_cnt = 0; inc_hit_cnt = 0; inc_mispr_cnt = 0;
    check("restart_done_cycle", n, 513);
    tick;
    check("restart_fd_once", fd_cnt - fd0, 1);
    stat_sel = 0; #1 check("sweep_br", 32'(stat_val), 0);
    stat_sel = 1; #1 check("sweep_hit", 32'(stat_val), 0);
    stat_sel = 2; #1 check("sweep_mis", 32'(stat_val), 0);
    stat_sel = 1;
    inc_hit_cnt = 1;
    check("hit_latency", 32'(stat_val), 0);
    tick;
    inc_hit_cnt = 0;
    #1;
    check("hit_one", 32'(stat_val), 1);
    inc_hit_cnt = 1;
    repeat (65533) tick;
    inc_hit_cnt = 0;
    #1;
    check("hit_fffe", 32'(stat_val), 32'hFFFE);
    inc_hit_cnt = 1;
    repeat (3) tick;
    check("hit_sat", 32'(stat_val), 32'hFFFF);
    inc_hit_cnt = 0;
    tick;
    check("hit_hold", 32'(stat_val), 32'hFFFF);
    stat_sel = 0;
    inc_br_cnt = 1;
    repeat (5) tick;
    inc_br_cnt = 0;
    #1;
    check("br_five", 32'(stat_val), 5);
    inc_mispr_cnt = 1;
    repeat (3) tick;
    inc_mispr_cnt = 0;
    stat_sel = 2; #1 check("mis_three", 32'(stat_val), 3);
    stat_sel = 3; #1 check("sel3_zero", 32'(stat_val), 0);
    stat_clr = 1; inc_br_cnt = 1;
    tick;
    stat_clr = 0; inc_br_cnt = 0;
    stat_sel = 0; #1 check("clr_br", 32'(stat_val), 0);
    stat_sel = 1; #1 check("clr_hit", 32'(stat_val), 0);
    inc_br_cnt = 1;
    repeat (2) tick;
    inc_br_cnt = 0;
    stat_sel = 0;
    #1;
    check("br_two", 32'(stat_val), 2);
    flush_req = 1;
    tick;
    flush_req = 0;
    repeat (42) tick;
    #1;
    check("ptr42", 32'(btb_wr_idx), 42);
    fd0 = fd_cnt;
    rst = 1;
    #1;
    check("midrst_we", 32'(btb_we), 0);
    check("midrst_stat", 32'(stat_val), 0);
    tick;
    rst = 0;
    #1;
    check("rerun_we", 32'(btb_we), 1);
    check("rerun_idx0", 32'(btb_wr_idx), 0);
    check("rerun_busy", 32'(busy), 1);
    check("rerun_br_clr", 32'(stat_val), 0);
    tick;
    check("rerun_idx1", 32'(btb_wr_idx), 1);
    n = 2;
    while (!flush_done && n < 600) begin tick; n++; end
    check("rerun_done_cycle", n, 513);
    tick;
    check("rerun_fd_once", fd_cnt - fd0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
